conv_sched: RTL and testbench
=============================

Name: conv_sched

Overview:
- Round-robin scheduler that shares one bit-serial convolution engine (shift registers, AND term, 4-bit accumulator, output register) between NREQ requesters.
- Accepts operand pairs through a valid/ready handshake and muxes the winner's operands onto the engine.
- Sequences the engine's load/shift/accumulate/output controls, then pulses a response tagged with the requester id.
- Sits between the requester blocks and the shared convolutor datapath; it holds no arithmetic datapath of its own.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 6, operand width in bits; equals the number of engine shift/accumulate cycles.
- IDW, $clog2(NREQ), width of requester id.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand A per requester; slice i is bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B per requester, same packing.
- req_ready  out  NREQ  one-hot acceptance, asserted only to the arbitration winner.
- eng_a, eng_b  out  WIDTH  winner's operands, driven to the engine in the load cycle.
- eng_load  out  1  engine loads eng_a/eng_b into its shift registers.
- eng_acc_clr  out  1  engine accumulator clears to 0.
- eng_shift  out  1  engine shifts operands right by one.
- eng_acc_en  out  1  engine adds the AND of operand bit 0 into the accumulator.
- eng_out_en  out  1  engine copies the accumulator into its output register.
- rsp_valid  out  1  one-cycle pulse; engine output register holds this job's result.
- rsp_id  out  IDW  requester id of the completed job; valid while rsp_valid=1.
- busy  out  1  high in ACC and OUT states.

Behaviour:
- Reset values (asynchronous): state IDLE, rr pointer 0, bit counter 0, rsp_id 0.
- All control outputs (req_ready, eng_*, rsp_valid) read 0 while reset is asserted.
- Grant: combinational round-robin over req_valid, starting at the rr pointer and searching upward with wrap-around.
- Grant is evaluated only in IDLE or RESP. No valid request means no grant and req_ready is all 0.
- Handshake: a request is accepted when req_valid[i] & req_ready[i].
- A requester may drop req_valid before it is granted; this has no side effects.
- Operands need only be stable in the accept cycle.
- Accept cycle (state IDLE or RESP):
  - eng_a/eng_b = slices of the winner; eng_load=1, eng_acc_clr=1.
  - Winner id is registered.
  - rr pointer <= (winner+1) mod NREQ.
  - Next state is ACC and the bit counter is cleared.
- ACC: eng_shift=1 and eng_acc_en=1 for exactly WIDTH cycles. The counter runs 0..WIDTH-1; at WIDTH-1 the next state is OUT.
- OUT: eng_out_en=1 for one cycle, then the next state is RESP.
- RESP:
  - rsp_valid=1 and rsp_id = registered winner.
  - If any request is valid, it is accepted in this same cycle (back-to-back); otherwise the next state is IDLE.
- Latency: accept at cycle t, ACC at t+1..t+WIDTH, OUT at t+WIDTH+1, rsp_valid at t+WIDTH+2.
- Sustained throughput: one job per WIDTH+2 cycles.
- eng_a/eng_b are 0 outside accept cycles.
- eng_load and eng_shift are never high together.
- Requests arriving in ACC or OUT wait with no ready.
- NREQ not a power of 2: pointer wrap uses explicit compare, never id overflow.
- Reset mid-operation: the in-flight job is abandoned with no rsp_valid, and the pointer returns to 0.

Decomposition:
- Package conv_pkg holds the state enum (IDLE, ACC, OUT, RESP, encoded in 2 bits), the default WIDTH/NREQ constants, and an eng_ctrl_t struct (load, acc_clr, shift, acc_en, out_en).
- One sub-module, rr_arbiter: combinational NREQ-way round-robin grant plus its registered pointer, with ports clock, reset, req, advance, grant (one-hot), grant_id.

Test Plan:
- Single request, WIDTH=6: req0 A=6'b101101, B=6'b111001, accepted at t. Required: eng_load at t; eng_shift/eng_acc_en at t+1..t+6; eng_out_en at t+7; rsp_valid at t+8 with rsp_id=0; engine output reads 3.
- Simultaneous req0 and req2 after reset. Required: req0 granted first; req2 accepted in req0's RESP cycle (t+8) and its rsp_valid at t+16 with rsp_id=2.
- All four requesters held valid continuously. Required: grant order 0,1,2,3,0,...; each rsp_id matches that order; exactly 8 cycles between rsp_valid pulses.
- Reset asserted during ACC cycle 3. Required: all controls 0 immediately; no rsp_valid; after release a req3 is granted and the pointer restarts from 0.
- req1 valid for 2 cycles during ACC, then dropped before RESP. Required: req_ready[1] never asserts, and the scheduler returns to IDLE after RESP.
- Same requester re-requesting back-to-back with others idle. Required: accepted in every RESP cycle, with rsp_valid every 8 cycles and rsp_id=1 each time.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution-engine scheduler.
package conv_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2,
      RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic load;
      logic acc_clr;
      logic shift;
      logic acc_en;
      logic out_en;
   } eng_ctrl_t;

endpackage

// File: rtl/conv_sched_if.sv
// Requester, engine-control and response signals of the scheduler.
interface conv_sched_if
   import conv_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = $clog2(NREQ)
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      eng_a;
   logic [WIDTH-1:0]      eng_b;
   logic                  eng_load;
   logic                  eng_acc_clr;
   logic                  eng_shift;
   logic                  eng_acc_en;
   logic                  eng_out_en;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic                  busy;

   modport master (
      input  req_valid, req_a, req_b,
      output req_ready, eng_a, eng_b, eng_load, eng_acc_clr, eng_shift,
             eng_acc_en, eng_out_en, rsp_valid, rsp_id, busy
   );

   modport slave (
      output req_valid, req_a, req_b,
      input  req_ready, eng_a, eng_b, eng_load, eng_acc_clr, eng_shift,
             eng_acc_en, eng_out_en, rsp_valid, rsp_id, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant with a registered priority pointer.
module rr_arbiter
   import conv_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);

   logic [IDW-1:0] ptr_q;
   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;
   logic           found;

   // Search upward from the pointer; the extra sum bit keeps wrap exact for any NREQ.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ))
            sum = sum - (IDW+1)'(NREQ);
         idx = sum[IDW-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         ptr_q <= '0;
      else if (advance)
         ptr_q <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
   end

endmodule

// File: rtl/conv_sched.sv
// Round-robin scheduler sequencing one shared bit-serial convolution engine.
module conv_sched
   import conv_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic         clock,
   input  logic         reset,
   conv_sched_if.master bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [NREQ-1:0]  arb_req;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_id;
   logic             advance;
   logic             grant_window;
   eng_ctrl_t        ctrl;

   // Reset masks the arbiter so no ready/load escapes while reset is held.
   assign grant_window = ~reset & ((state_q == IDLE) || (state_q == RESP));
   assign arb_req      = grant_window ? bus.req_valid : '0;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clock    (clock),
      .reset    (reset),
      .req      (arb_req),
      .advance  (advance),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      id_d          = id_q;
      ctrl          = '0;
      advance       = 1'b0;
      bus.eng_a     = '0;
      bus.eng_b     = '0;
      bus.rsp_valid = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (state_q == RESP) begin
               bus.rsp_valid = 1'b1;
               state_d       = IDLE;
            end
            if (|grant) begin
               ctrl.load    = 1'b1;
               ctrl.acc_clr = 1'b1;
               advance      = 1'b1;
               id_d         = grant_id;
               cnt_d        = '0;
               state_d      = ACC;
               bus.eng_a    = bus.req_a[grant_id*WIDTH +: WIDTH];
               bus.eng_b    = bus.req_b[grant_id*WIDTH +: WIDTH];
            end
         end
         ACC: begin
            ctrl.shift  = 1'b1;
            ctrl.acc_en = 1'b1;
            if (cnt_q == CW'(WIDTH-1))
               state_d = OUT;
            else
               cnt_d = cnt_q + CW'(1);
         end
         OUT: begin
            ctrl.out_en = 1'b1;
            state_d     = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready   = grant;
   assign bus.eng_load    = ctrl.load;
   assign bus.eng_acc_clr = ctrl.acc_clr;
   assign bus.eng_shift   = ctrl.shift;
   assign bus.eng_acc_en  = ctrl.acc_en;
   assign bus.eng_out_en  = ctrl.out_en;
   assign bus.rsp_id      = id_q;
   assign bus.busy        = (state_q == ACC) || (state_q == OUT);

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with a behavioural model of the shared engine.
module tb_conv_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 6;
   localparam int IDW   = 2;

   // ctl = {load, acc_clr, shift, acc_en, out_en, rsp_valid, busy}
   localparam logic [6:0] C_IDLE     = 7'b0000000;
   localparam logic [6:0] C_ACCEPT   = 7'b1100000;
   localparam logic [6:0] C_ACC      = 7'b0011001;
   localparam logic [6:0] C_OUT      = 7'b0000101;
   localparam logic [6:0] C_RESP     = 7'b0000010;
   localparam logic [6:0] C_RESP_ACC = 7'b1100010;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   nvec  = 0;
   int   nerr  = 0;

   always #5 clock = ~clock;

   conv_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   conv_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [WIDTH-1:0] sa, sb;
   logic [3:0]       acc, eng_out;
   logic [6:0]       ctl;

   always_ff @(posedge clock) begin
      if (bus.eng_load) begin
         sa <= bus.eng_a;
         sb <= bus.eng_b;
      end else if (bus.eng_shift) begin
         sa <= sa >> 1;
         sb <= sb >> 1;
      end
      if (bus.eng_acc_clr)
         acc <= '0;
      else if (bus.eng_acc_en)
         acc <= acc + {3'b000, sa[0] & sb[0]};
      if (bus.eng_out_en)
         eng_out <= acc;
   end

   assign ctl = {bus.eng_load, bus.eng_acc_clr, bus.eng_shift, bus.eng_acc_en,
                 bus.eng_out_en, bus.rsp_valid, bus.busy};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.req_a[i*WIDTH +: WIDTH] = a;
      bus.req_b[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Walks ACC and OUT after an accept, leaving time in the RESP cycle.
   task automatic walk_job(input int exp_id, input int exp_res,
                           input logic [NREQ-1:0] v1, input logic [NREQ-1:0] mid);
      for (int i = 1; i <= WIDTH; i++) begin
         @(negedge clock);
         if (i == 1) bus.req_valid = v1;
         if (mid != '0 && i == 2) bus.req_valid = mid;
         if (mid != '0 && i == 4) bus.req_valid = '0;
         #1;
         chk("acc_ctl", 32'(ctl), 32'(C_ACC));
         chk("acc_ready", 32'(bus.req_ready), 32'd0);
         if (i == 1) chk("acc_operands_zero", 32'({bus.eng_a, bus.eng_b}), 32'd0);
      end
      @(negedge clock);
      #1;
      chk("out_ctl", 32'(ctl), 32'(C_OUT));
      @(negedge clock);
      #1;
      chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
      chk("eng_result", 32'(eng_out), 32'(exp_res));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      // Reset: requests present but all controls must read 0.
      @(negedge clock);
      bus.req_valid = '1;
      #1;
      chk("rst_ctl", 32'(ctl), 32'(C_IDLE));
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_eng_a", 32'(bus.eng_a), 32'd0);
      @(negedge clock);
      bus.req_valid = '0;
      reset = 1'b0;
      #1;
      chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

      // Single request from req0: AND = 101001 -> 3.
      @(negedge clock);
      set_op(0, 6'b101101, 6'b111001);
      bus.req_valid = 4'b0001;
      #1;
      chk("t1_ready", 32'(bus.req_ready), 32'h1);
      chk("t1_ctl", 32'(ctl), 32'(C_ACCEPT));
      chk("t1_eng_a", 32'(bus.eng_a), 32'(6'b101101));
      chk("t1_eng_b", 32'(bus.eng_b), 32'(6'b111001));
      walk_job(0, 3, 4'b0000, 4'b0000);
      chk("t1_resp_ctl", 32'(ctl), 32'(C_RESP));
      @(negedge clock);
      #1;
      chk("t1_idle", 32'(ctl), 32'(C_IDLE));

      // req0 and req2 together after reset: 0 first, 2 accepted in 0's RESP.
      pulse_reset();
      @(negedge clock);
      set_op(2, 6'b111111, 6'b011111);
      bus.req_valid = 4'b0101;
      #1;
      chk("t2_ready0", 32'(bus.req_ready), 32'h1);
      chk("t2_ctl0", 32'(ctl), 32'(C_ACCEPT));
      walk_job(0, 3, 4'b0100, 4'b0000);
      chk("t2_resp0_ctl", 32'(ctl), 32'(C_RESP_ACC));
      chk("t2_ready2", 32'(bus.req_ready), 32'h4);
      chk("t2_eng_a2", 32'(bus.eng_a), 32'(6'b111111));
      walk_job(2, 5, 4'b0000, 4'b0000);
      chk("t2_resp2_ctl", 32'(ctl), 32'(C_RESP));
      @(negedge clock);
      #1;
      chk("t2_idle", 32'(ctl), 32'(C_IDLE));

      // All four held valid: order 0,1,2,3,0,1; result = id+1.
      pulse_reset();
      @(negedge clock);
      set_op(0, 6'b111111, 6'b000001);
      set_op(1, 6'b111111, 6'b000011);
      set_op(2, 6'b111111, 6'b000111);
      set_op(3, 6'b111111, 6'b001111);
      bus.req_valid = 4'b1111;
      #1;
      chk("t3_ready0", 32'(bus.req_ready), 32'h1);
      chk("t3_ctl0", 32'(ctl), 32'(C_ACCEPT));
      for (int k = 1; k <= 5; k++) begin
         walk_job((k-1) % 4, ((k-1) % 4) + 1, 4'b1111, 4'b0000);
         chk("t3_resp_ctl", 32'(ctl), 32'(C_RESP_ACC));
         chk("t3_rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      end
      walk_job(1, 2, 4'b0000, 4'b0000);
      chk("t3_last_ctl", 32'(ctl), 32'(C_RESP));
      @(negedge clock);
      #1;
      chk("t3_idle", 32'(ctl), 32'(C_IDLE));

      // Reset in ACC cycle 3, then req3 granted and the pointer wraps to 0.
      @(negedge clock);
      set_op(3, 6'b111000, 6'b101000);
      set_op(1, 6'b011110, 6'b011110);
      bus.req_valid = 4'b0100;
      #1;
      chk("t4_ready2", 32'(bus.req_ready), 32'h4);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clock);
         if (i == 1) bus.req_valid = '0;
         #1;
         chk("t4_acc_ctl", 32'(ctl), 32'(C_ACC));
      end
      reset = 1'b1;
      bus.req_valid = 4'b1000;
      #1;
      chk("t4_rst_ctl", 32'(ctl), 32'(C_IDLE));
      chk("t4_rst_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_rst_id", 32'(bus.rsp_id), 32'd0);
      @(negedge clock);
      #1;
      chk("t4_rst_hold", 32'(ctl), 32'(C_IDLE));
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("t4_ready3", 32'(bus.req_ready), 32'h8);
      chk("t4_ctl3", 32'(ctl), 32'(C_ACCEPT));
      walk_job(3, 2, 4'b1010, 4'b0000);
      chk("t4_resp_ctl", 32'(ctl), 32'(C_RESP_ACC));
      chk("t4_wrap_ready1", 32'(bus.req_ready), 32'h2);

      // req1 valid for two ACC cycles then dropped: never ready, back to IDLE.
      walk_job(1, 4, 4'b0000, 4'b0010);
      chk("t5_resp_ctl", 32'(ctl), 32'(C_RESP));
      chk("t5_resp_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
      #1;
      chk("t5_idle", 32'(ctl), 32'(C_IDLE));

      // req1 re-requests back-to-back: AND = 100010 -> 2.
      @(negedge clock);
      set_op(1, 6'b110011, 6'b101010);
      bus.req_valid = 4'b0010;
      #1;
      chk("t6_ready", 32'(bus.req_ready), 32'h2);
      chk("t6_ctl", 32'(ctl), 32'(C_ACCEPT));
      for (int k = 1; k <= 3; k++) begin
         walk_job(1, 2, 4'b0010, 4'b0000);
         chk("t6_resp_ctl", 32'(ctl), 32'(C_RESP_ACC));
         chk("t6_resp_ready", 32'(bus.req_ready), 32'h2);
      end
      walk_job(1, 2, 4'b0000, 4'b0000);
      chk("t6_last_ctl", 32'(ctl), 32'(C_RESP));
      @(negedge clock);
      #1;
      chk("t6_idle", 32'(ctl), 32'(C_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
